// File: rtl/dpe_tx_arb_if.sv
// ---------------------------------------------------------------------------
// dpe_tx_arb_if
//
// Bundle of the AXI-Stream signals around the TX arbiter: the packed per-port
// requester streams on one side and the single stream towards the MAC on the
// other.
//
//   in_tdata   [NUM_PORTS*DATA_WIDTH]   requester data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_tkeep   [NUM_PORTS*DATA_WIDTH/8] requester byte enables, packed per port
//   in_tuser   [NUM_PORTS*USER_WIDTH]   requester sideband, packed per port
//   in_tvalid  [NUM_PORTS]              per-port valid
//   in_tlast   [NUM_PORTS]              per-port end of frame
//   in_tready  [NUM_PORTS]              per-port ready (driven by the arbiter)
//   out_tdata / out_tkeep / out_tuser   stream towards the MAC
//   out_tvalid / out_tlast              stream towards the MAC
//   out_tready                          backpressure from the MAC
//
// Modports:
//   slave  - the arbiter's view (consumes requester streams, drives the MAC side)
//   master - the environment's view (drives requesters and MAC backpressure)
// ---------------------------------------------------------------------------
interface dpe_tx_arb_if #(
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1,
   parameter int NUM_PORTS  = 4
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata;
   logic [NUM_PORTS*KEEP_WIDTH-1:0] in_tkeep;
   logic [NUM_PORTS*USER_WIDTH-1:0] in_tuser;
   logic [NUM_PORTS-1:0]            in_tvalid;
   logic [NUM_PORTS-1:0]            in_tlast;
   logic [NUM_PORTS-1:0]            in_tready;

   logic [DATA_WIDTH-1:0]           out_tdata;
   logic [KEEP_WIDTH-1:0]           out_tkeep;
   logic [USER_WIDTH-1:0]           out_tuser;
   logic                            out_tvalid;
   logic                            out_tlast;
   logic                            out_tready;

   modport slave (
      input  in_tdata, in_tkeep, in_tuser, in_tvalid, in_tlast,
      output in_tready,
      output out_tdata, out_tkeep, out_tuser, out_tvalid, out_tlast,
      input  out_tready
   );

   modport master (
      output in_tdata, in_tkeep, in_tuser, in_tvalid, in_tlast,
      input  in_tready,
      input  out_tdata, out_tkeep, out_tuser, out_tvalid, out_tlast,
      output out_tready
   );
endinterface

// File: rtl/dpe_tx_arb.sv
// ---------------------------------------------------------------------------
// dpe_tx_arb
//
// Packet-granular round-robin arbiter sharing the MAC TX AXI-Stream input
// between NUM_PORTS requesters. A granted port owns the output until its tlast
// beat is accepted, so frames are never interleaved. A one-beat output register
// decouples the MAC from the requester paths.
//
// Ports:
//   clk          single clock
//   rst_n        asynchronous-assert, active-low reset
//   bus          dpe_tx_arb_if.slave: requester streams in, MAC stream out
//   cfg_port_en  per-port enable mask, only looked at while arbitrating
//   grant        one-hot current owner, zero while idle
//   busy         high while a packet is being passed or the output holds a beat
// ---------------------------------------------------------------------------
module dpe_tx_arb #(
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1,
   parameter int NUM_PORTS  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dpe_tx_arb_if.slave          bus,
   input  logic [NUM_PORTS-1:0] cfg_port_en,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 busy
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PASS = 1'b1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]            state_q,      state_d;
   logic [NUM_PORTS-1:0]  grant_q,      grant_d;
   logic [IDX_W-1:0]      gidx_q,       gidx_d;       // index form of grant_q
   logic [IDX_W-1:0]      last_grant_q, last_grant_d;

   logic [DATA_WIDTH-1:0] out_tdata_q,  out_tdata_d;
   logic [KEEP_WIDTH-1:0] out_tkeep_q,  out_tkeep_d;
   logic [USER_WIDTH-1:0] out_tuser_q,  out_tuser_d;
   logic                  out_tvalid_q, out_tvalid_d;
   logic                  out_tlast_q,  out_tlast_d;

   // ------------------------------------------------------------------------
   // Per-port views of the packed requester buses
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] port_tdata [NUM_PORTS];
   logic [KEEP_WIDTH-1:0] port_tkeep [NUM_PORTS];
   logic [USER_WIDTH-1:0] port_tuser [NUM_PORTS];
   logic [NUM_PORTS-1:0]  in_tready_w;

   // The output register can take a beat when it is empty or being drained.
   logic out_room;
   assign out_room = bus.out_tready | ~out_tvalid_q;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_tdata[gi]  = bus.in_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign port_tkeep[gi]  = bus.in_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign port_tuser[gi]  = bus.in_tuser[gi*USER_WIDTH +: USER_WIDTH];
      // Ready never looks at in_tvalid, so requesters may wait for ready.
      assign in_tready_w[gi] = (state_q == ST_PASS) & grant_q[gi] & out_room;
   end

   assign bus.in_tready = in_tready_w;

   // ------------------------------------------------------------------------
   // Round-robin selection: first request strictly after last_grant_q,
   // wrapping, with last_grant_q itself checked last.
   // ------------------------------------------------------------------------
   logic [NUM_PORTS-1:0] req;
   logic                 sel_found;
   logic [IDX_W-1:0]     sel_idx;
   logic [IDX_W-1:0]     cand_idx;
   int                   cand;

   assign req = bus.in_tvalid & cfg_port_en;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand     = (int'(last_grant_q) + k) % NUM_PORTS;
         cand_idx = IDX_W'(cand);
         if (!sel_found && req[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Beat transfer from the granted port
   // ------------------------------------------------------------------------
   logic accept;
   logic sel_tlast;

   assign accept    = (state_q == ST_PASS) & bus.in_tvalid[gidx_q] & out_room;
   assign sel_tlast = bus.in_tlast[gidx_q];

   // ------------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      last_grant_d = last_grant_q;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               gidx_d           = sel_idx;
               state_d          = ST_PASS;
            end
         end
         ST_PASS: begin
            // Ownership ends only on an accepted tlast beat; a stalled or
            // disabled owner keeps the grant.
            if (accept && sel_tlast) begin
               last_grant_d = gidx_q;
               grant_d      = '0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output register next state
   // ------------------------------------------------------------------------
   always_comb begin
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tuser_d  = out_tuser_q;
      out_tvalid_d = out_tvalid_q;
      out_tlast_d  = out_tlast_q;

      if (accept) begin
         // Covers the simultaneous drain-and-load case: valid stays high.
         out_tdata_d  = port_tdata[gidx_q];
         out_tkeep_d  = port_tkeep[gidx_q];
         out_tuser_d  = port_tuser[gidx_q];
         out_tlast_d  = sel_tlast;
         out_tvalid_d = 1'b1;
      end else if (bus.out_tready) begin
         out_tvalid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         // Port 0 gets first priority after reset.
         last_grant_q <= IDX_W'(NUM_PORTS - 1);
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tuser_q  <= '0;
         out_tvalid_q <= 1'b0;
         out_tlast_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         last_grant_q <= last_grant_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tuser_q  <= out_tuser_d;
         out_tvalid_q <= out_tvalid_d;
         out_tlast_q  <= out_tlast_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.out_tdata  = out_tdata_q;
   assign bus.out_tkeep  = out_tkeep_q;
   assign bus.out_tuser  = out_tuser_q;
   assign bus.out_tvalid = out_tvalid_q;
   assign bus.out_tlast  = out_tlast_q;

   assign grant = grant_q;
   assign busy  = (state_q == ST_PASS) | out_tvalid_q;

endmodule

// File: doc/dpe_tx_arb.md
# dpe_tx_arb

Packet-granular round-robin arbiter that shares the single 128-bit AXI-Stream TX input of the Ethernet MAC/FIFO between up to NUM_PORTS requesters, for example DPE egress and CPU-injected frames. Once granted, a port owns the output until its tlast beat is accepted, so frames are never interleaved. It sits between the requester streams and the MAC `tx_axis_*` port. A one-beat output register breaks the combinational path to the MAC.

## Interface
- DATA_WIDTH, 128, tdata width; tkeep width is DATA_WIDTH/8
- USER_WIDTH, 1, tuser width, forwarded unchanged
- NUM_PORTS, 4, number of requesters (2..8)
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous assert, active-low
- in_tdata  in  NUM_PORTS*DATA_WIDTH  packed per port; port p is at slice [p*DATA_WIDTH +: DATA_WIDTH]
- in_tkeep  in  NUM_PORTS*DATA_WIDTH/8  packed per port
- in_tuser  in  NUM_PORTS*USER_WIDTH  packed per port
- in_tvalid  in  NUM_PORTS  per-port valid
- in_tlast  in  NUM_PORTS  per-port last
- in_tready  out  NUM_PORTS  per-port ready
- out_tdata / out_tkeep / out_tuser  out  DATA_WIDTH / DATA_WIDTH/8 / USER_WIDTH  to MAC
- out_tvalid, out_tlast  out  1  to MAC
- out_tready  in  1  from MAC
- cfg_port_en  in  NUM_PORTS  per-port enable mask
- grant  out  NUM_PORTS  one-hot current owner; all-zero when idle
- busy  out  1  high in PASS state or while out_tvalid is high

## Operation
- FSM states:
  - IDLE: requests are computed as in_tvalid & cfg_port_en.
    - If any request is set, select the first requester searching from last_grant+1 upward, wrapping modulo NUM_PORTS. Register grant and go to PASS.
    - With no request, stay in IDLE.
  - PASS: in_tready[g] = out_tready | ~out_tvalid; all other in_tready are 0.
    - An accepted beat (in_tvalid[g] & in_tready[g]) loads the output register.
    - When the accepted beat has tlast: set last_grant = g, clear grant, return to IDLE.
- last_grant resets to NUM_PORTS-1, so port 0 has first priority after reset.
- Output register:
  - Loads on an accepted input beat.
  - Clears out_tvalid on out_tready when no new beat is loaded in the same cycle.
  - Simultaneous drain and load keeps out_tvalid at 1 with the new data.
- The arbiter does not inspect or modify tdata, tkeep or tuser.
- cfg_port_en is sampled only in IDLE. Deasserting a port's enable while it holds the grant does not abort its packet; the packet completes normally.
- A granted port that drops tvalid mid-packet keeps the grant indefinitely (no timeout). in_tvalid of non-granted ports is ignored.
- Reset mid-packet: the FSM returns to IDLE, the output register is invalidated and the partial frame is lost downstream. Requesters must also be reset.

## Timing
- Reset values:
  - grant = 0, busy = 0, all in_tready = 0
  - out_tvalid = 0, out_tlast = 0, out_tdata/tkeep/tuser = 0
- Grant latency: a request seen in IDLE in cycle N gives grant in cycle N+1, and in_tready[g] can be high in cycle N+1.
- Data latency: an input beat accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 beat per cycle inside a packet while out_tready = 1.
- One idle arbitration cycle follows every tlast acceptance, so the minimum per-packet cost is beats + 1 cycles.
- in_tready depends combinationally on out_tready and out_tvalid only, never on in_tvalid.

## Test plan
- Single port 0: send an 11-beat packet with last tkeep = 16'h03FF and out_tready = 1.
  - Required: grant = 4'b0001 one cycle after tvalid; 11 beats out identical in order; tlast only on beat 11; grant = 0 after it.
- Ports 0 and 2 both hold continuous 5-beat packets.
  - Required: output packet order 0, 2, 0, 2; no interleaved beats; exactly one idle cycle between packets.
- Backpressure: toggle out_tready 1,0,1,1,0 during a 4-beat packet.
  - Required: no beat is lost or duplicated; out_* stays stable while out_tvalid = 1 and out_tready = 0.
- Enable mask: clear cfg_port_en[1] mid-packet on port 1, with port 3 also requesting.
  - Required: port 1's packet completes; the next grant is 4'b1000; port 1 is not granted again while disabled.
- Single-beat packets: ports 0–3 each send a 1-beat packet with tlast = 1.
  - Required: outputs appear in order 0, 1, 2, 3, one every 2 cycles.
- Reset mid-packet: assert rst_n = 0 on beat 3 of 6.
  - Required: out_tvalid = 0, grant = 0 and in_tready = 0 asynchronously. After release, the next request from port 0 wins.
